// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: default width, ALU function codes,
// request op encodings and the sequencer state type.
package alu_pkg;

    // Default datapath width of the sequencer and the external ALU.
    localparam int NUM_BITS = 16;

    // Function codes understood by the external combinational ALU.
    localparam logic [3:0] FUNC_ADD    = 4'b0000;
    localparam logic [3:0] FUNC_PASS_A = 4'b0010;
    localparam logic [3:0] FUNC_SHL    = 4'b1100;
    localparam logic [3:0] FUNC_ZERO   = 4'b1111;

    // Request op encodings.
    localparam logic [1:0] OP_SINGLE = 2'b00;
    localparam logic [1:0] OP_MUL    = 2'b01;
    localparam logic [1:0] OP_RSVD2  = 2'b10;
    localparam logic [1:0] OP_RSVD3  = 2'b11;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SINGLE    = 3'd1,
        ST_MUL_ADD   = 3'd2,
        ST_MUL_SHIFT = 3'd3,
        ST_DONE      = 3'd4
    } seq_state_e;

    // Shift-and-add step: add the multiplicand when the current multiplier
    // bit is set, otherwise pass the accumulator through unchanged.
    function automatic logic [3:0] mul_add_func(input logic mplier_lsb);
        logic [3:0] func;
        if (mplier_lsb) begin
            func = FUNC_ADD;
        end else begin
            func = FUNC_PASS_A;
        end
        return func;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response bus of the ALU sequencer. The master is the requester that
// issues operations and consumes results; the slave is the sequencer itself.
interface alu_sequencer_if #(
    parameter int NUM_BITS = 16
);
    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_op;
    logic [3:0]          req_func;
    logic [NUM_BITS-1:0] req_a;
    logic [NUM_BITS-1:0] req_b;
    logic                resp_valid;
    logic                resp_ready;
    logic [NUM_BITS-1:0] resp_data;
    logic                resp_flag;

    // Requester side: drives requests and accepts responses.
    modport master (
        output req_valid, req_op, req_func, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_flag
    );

    // Sequencer side: accepts requests and presents responses.
    modport slave (
        input  req_valid, req_op, req_func, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_flag
    );
endinterface

// File: rtl/alu_sequencer.sv
// ALU sequencer: drives an external combinational ALU either for one single
// operation or for a shift-and-add multiply (one add step and one shift step
// per multiplier bit). All ALU-facing and response outputs are registered;
// values for the next state are computed on the transition into it.
module alu_sequencer #(
    parameter int NUM_BITS  = alu_pkg::NUM_BITS,
    parameter int MUL_ITERS = NUM_BITS
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_sequencer_if.slave      bus,
    output logic [NUM_BITS-1:0] alu_a,
    output logic [NUM_BITS-1:0] alu_b,
    output logic [3:0]          alu_func,
    input  logic [NUM_BITS-1:0] alu_c,
    input  logic                alu_flag
);
    import alu_pkg::*;

    localparam int                  CNT_W     = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
    localparam logic [CNT_W-1:0]    LAST_ITER = CNT_W'(MUL_ITERS - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [NUM_BITS-1:0] DATA_ZERO = {NUM_BITS{1'b0}};

    seq_state_e          state_q,      state_d;
    logic [NUM_BITS-1:0] acc_q,        acc_d;
    logic [NUM_BITS-1:0] mcand_q,      mcand_d;
    logic [NUM_BITS-1:0] mplier_q,     mplier_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [NUM_BITS-1:0] alu_a_q,      alu_a_d;
    logic [NUM_BITS-1:0] alu_b_q,      alu_b_d;
    logic [3:0]          alu_func_q,   alu_func_d;
    logic                resp_valid_q, resp_valid_d;
    logic [NUM_BITS-1:0] resp_data_q,  resp_data_d;
    logic                resp_flag_q,  resp_flag_d;
    logic [NUM_BITS-1:0] mplier_shift_s;

    // Multiplier after this iteration's shift; its LSB selects the next add step.
    assign mplier_shift_s = mplier_q >> 1;

    // Ready only while idle, and forced low while reset is held.
    assign bus.req_ready  = (state_q == ST_IDLE) && reset_n;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_flag  = resp_flag_q;
    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_func       = alu_func_q;

    // Next-state and next-output computation for the sequencer FSM.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_func_d   = alu_func_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_flag_d  = resp_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    case (bus.req_op)
                        OP_SINGLE: begin
                            state_d    = ST_SINGLE;
                            alu_a_d    = bus.req_a;
                            alu_b_d    = bus.req_b;
                            alu_func_d = bus.req_func;
                        end
                        OP_MUL: begin
                            // First add step: acc starts at zero, mcand = A.
                            state_d    = ST_MUL_ADD;
                            acc_d      = DATA_ZERO;
                            mcand_d    = bus.req_a;
                            mplier_d   = bus.req_b;
                            cnt_d      = CNT_ZERO;
                            alu_a_d    = DATA_ZERO;
                            alu_b_d    = bus.req_a;
                            alu_func_d = mul_add_func(bus.req_b[0]);
                        end
                        OP_RSVD2, OP_RSVD3: begin
                            // Reserved ops run as a single op that yields zero.
                            state_d    = ST_SINGLE;
                            alu_a_d    = bus.req_a;
                            alu_b_d    = bus.req_b;
                            alu_func_d = FUNC_ZERO;
                        end
                        default: begin
                            state_d    = ST_SINGLE;
                            alu_a_d    = bus.req_a;
                            alu_b_d    = bus.req_b;
                            alu_func_d = FUNC_ZERO;
                        end
                    endcase
                end else begin
                    alu_a_d    = DATA_ZERO;
                    alu_b_d    = DATA_ZERO;
                    alu_func_d = FUNC_ZERO;
                end
            end

            ST_SINGLE: begin
                state_d      = ST_DONE;
                resp_valid_d = 1'b1;
                resp_data_d  = alu_c;
                resp_flag_d  = alu_flag;
                alu_a_d      = DATA_ZERO;
                alu_b_d      = DATA_ZERO;
                alu_func_d   = FUNC_ZERO;
            end

            ST_MUL_ADD: begin
                // Accumulate, then set up the shift of the multiplicand.
                state_d    = ST_MUL_SHIFT;
                acc_d      = alu_c;
                alu_a_d    = mcand_q;
                alu_b_d    = DATA_ZERO;
                alu_func_d = FUNC_SHL;
            end

            ST_MUL_SHIFT: begin
                mcand_d  = alu_c;
                mplier_d = mplier_shift_s;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == LAST_ITER) begin
                    // Product is the low NUM_BITS of the accumulator.
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = acc_q;
                    resp_flag_d  = 1'b0;
                    alu_a_d      = DATA_ZERO;
                    alu_b_d      = DATA_ZERO;
                    alu_func_d   = FUNC_ZERO;
                end else begin
                    state_d    = ST_MUL_ADD;
                    alu_a_d    = acc_q;
                    alu_b_d    = alu_c;
                    alu_func_d = mul_add_func(mplier_shift_s[0]);
                end
            end

            ST_DONE: begin
                // Response held stable until the consumer takes it.
                if (bus.resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end else begin
                    state_d      = ST_DONE;
                end
                alu_a_d    = DATA_ZERO;
                alu_b_d    = DATA_ZERO;
                alu_func_d = FUNC_ZERO;
            end

            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                alu_a_d      = DATA_ZERO;
                alu_b_d      = DATA_ZERO;
                alu_func_d   = FUNC_ZERO;
            end
        endcase
    end

    // FSM state, datapath and registered outputs; reset aborts any operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= DATA_ZERO;
            mcand_q      <= DATA_ZERO;
            mplier_q     <= DATA_ZERO;
            cnt_q        <= CNT_ZERO;
            alu_a_q      <= DATA_ZERO;
            alu_b_q      <= DATA_ZERO;
            alu_func_q   <= FUNC_ZERO;
            resp_valid_q <= 1'b0;
            resp_data_q  <= DATA_ZERO;
            resp_flag_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_func_q   <= alu_func_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_flag_q  <= resp_flag_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus pushes expected responses, a
// monitor pops and compares them (data, flag, latency) on each response
// handshake. The external ALU is modelled here.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int NB = 16;

    typedef struct {
        logic [NB-1:0] data;
        logic          flag;
        int            acc_cyc;
        int            lat;
    } exp_t;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic [NB-1:0] alu_a;
    logic [NB-1:0] alu_b;
    logic [NB-1:0] alu_c;
    logic [3:0]    alu_func;
    logic          alu_flag;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_acc = 0;
    exp_t exp_q[$];

    // Monitor state
    logic          mon_pv  = 1'b0;
    logic          mon_phs = 1'b0;
    logic [NB-1:0] mon_pd  = '0;
    logic          mon_pf  = 1'b0;
    int            mon_rise = 0;

    alu_sequencer_if #(.NUM_BITS(NB)) bus ();

    alu_sequencer #(.NUM_BITS(NB), .MUL_ITERS(NB)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_func (alu_func),
        .alu_c    (alu_c),
        .alu_flag (alu_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External ALU model: add (carry as flag), pass A, equal, shift left, zero.
    always_comb begin
        alu_c    = '0;
        alu_flag = 1'b0;
        case (alu_func)
            4'b0000: {alu_flag, alu_c} = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0010: alu_c = alu_a;
            4'b0111: begin
                alu_c    = alu_a;
                alu_flag = (alu_a == alu_b);
            end
            4'b1100: alu_c = alu_a << 1;
            4'b1111: alu_c = '0;
            default: alu_c = alu_a ^ alu_b;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  {31'd0, bus.req_ready},  32'd0);
        check({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        check({tag, "_resp_data"},  {16'd0, bus.resp_data},  32'd0);
        check({tag, "_resp_flag"},  {31'd0, bus.resp_flag},  32'd0);
        check({tag, "_alu_a"},      {16'd0, alu_a},          32'd0);
        check({tag, "_alu_b"},      {16'd0, alu_b},          32'd0);
        check({tag, "_alu_func"},   {28'd0, alu_func},       32'hF);
    endtask

    // Present one request until accepted; push its expected response.
    task automatic send(input logic [1:0] op, input logic [3:0] func,
                        input logic [NB-1:0] a, input logic [NB-1:0] b,
                        input logic [NB-1:0] ed, input logic ef, input int lat);
        logic got;
        exp_t e;
        got           = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_func  = func;
        bus.req_a     = a;
        bus.req_b     = b;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                got       = 1'b1;
                e.data    = ed;
                e.flag    = ef;
                e.acc_cyc = cyc;
                e.lat     = lat;
                exp_q.push_back(e);
                last_acc  = cyc;
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        check("accept", {31'd0, got}, 32'd1);
    endtask

    // Wait for all expected responses to be consumed.
    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.resp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: response stability while stalled, then scoreboard compare on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                mon_pv  = 1'b0;
                mon_phs = 1'b0;
            end else begin
                if (bus.resp_valid && !mon_pv) mon_rise = cyc;
                if (bus.resp_valid && mon_pv && !mon_phs) begin
                    check("hold_data", {16'd0, bus.resp_data}, {16'd0, mon_pd});
                    check("hold_flag", {31'd0, bus.resp_flag}, {31'd0, mon_pf});
                end
                if (bus.resp_valid && bus.resp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_resp: actual data 0x%0h required no response", bus.resp_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_data", {16'd0, bus.resp_data}, {16'd0, e.data});
                        check("resp_flag", {31'd0, bus.resp_flag}, {31'd0, e.flag});
                        check("latency", mon_rise - e.acc_cyc, e.lat);
                    end
                end
                mon_pv  = bus.resp_valid;
                mon_phs = bus.resp_valid && bus.resp_ready;
                mon_pd  = bus.resp_data;
                mon_pf  = bus.resp_flag;
            end
        end
    end

    // Directed stimulus.
    initial begin
        int  a0;
        logic saw;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_func   = 4'b0000;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;

        // Power-on reset
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("ready_after_por", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single ops
        send(OP_SINGLE, FUNC_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 2);
        send(OP_SINGLE, 4'b0111, 16'h1234, 16'h1234, 16'h1234, 1'b1, 2);
        send(OP_SINGLE, 4'b0111, 16'h1234, 16'h1235, 16'h1234, 1'b0, 2);
        send(OP_SINGLE, FUNC_ADD, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 2);
        // Reserved ops yield zero regardless of func
        send(OP_RSVD2, FUNC_ADD, 16'h1234, 16'h0001, 16'h0000, 1'b0, 2);
        send(OP_RSVD3, 4'b0111, 16'h5555, 16'h5555, 16'h0000, 1'b0, 2);
        drain();

        // Multiplies
        send(OP_MUL, 4'b0000, 16'h0003, 16'h0005, 16'h000F, 1'b0, 33);
        send(OP_MUL, 4'b0000, 16'h0100, 16'h0100, 16'h0000, 1'b0, 33);
        send(OP_MUL, 4'b0111, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 33);
        send(OP_MUL, 4'b0000, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 33);
        drain();

        // Consumer stall: response held, no new accept
        bus.resp_ready = 1'b0;
        send(OP_SINGLE, FUNC_ADD, 16'h1111, 16'h2222, 16'h3333, 1'b0, 2);
        saw = 1'b0;
        for (int i = 0; i < 10 && !saw; i++) begin
            @(negedge clk);
            if (bus.resp_valid) saw = 1'b1;
        end
        check("stall_resp_seen", {31'd0, saw}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.req_valid = 1'b1;
            bus.req_op    = OP_SINGLE;
            bus.req_func  = FUNC_ADD;
            bus.req_a     = 16'h0F0F;
            bus.req_b     = 16'h0001;
            @(negedge clk);
            check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
            check("stall_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        drain();

        // Reset during multiply iteration 7
        send(OP_MUL, 4'b0000, 16'h0003, 16'h0005, 16'h000F, 1'b0, 33);
        repeat (14) @(posedge clk);
        #1;
        check("it7_alu_a", {16'd0, alu_a}, 32'h000F);
        check("it7_alu_b", {16'd0, alu_b}, 32'h0180);
        check("it7_alu_func", {28'd0, alu_func}, {28'd0, FUNC_PASS_A});
        #2 reset_n = 1'b0;
        exp_q.delete();
        #1 check_reset_outputs("mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("ready_after_mid", {31'd0, bus.req_ready}, 32'd1);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.resp_valid) saw = 1'b1;
        end
        check("no_resp_after_abort", {31'd0, saw}, 32'd0);
        @(posedge clk);
        #1;
        send(OP_SINGLE, FUNC_ADD, 16'h0002, 16'h0003, 16'h0005, 1'b0, 2);
        drain();

        // Back-to-back: next accept one idle cycle after each handshake
        send(OP_SINGLE, FUNC_ADD, 16'h0010, 16'h0020, 16'h0030, 1'b0, 2);
        a0 = last_acc;
        send(OP_SINGLE, FUNC_ADD, 16'h0100, 16'h0001, 16'h0101, 1'b0, 2);
        check("b2b_gap1", last_acc - a0, 32'd3);
        a0 = last_acc;
        send(OP_SINGLE, 4'b0111, 16'hABCD, 16'hABCD, 16'hABCD, 1'b1, 2);
        check("b2b_gap2", last_acc - a0, 32'd3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter NUM_BITS, default 16, datapath width.
REQ-002 SHALL have parameter MUL_ITERS, default 16, multiply iteration count (equals NUM_BITS).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  sequencer can accept a request.
REQ-007 req_op  input  2  00 single ALU op, 01 multiply, 10/11 reserved.
REQ-008 req_func  input  4  ALU function code for single op.
REQ-009 req_a / req_b  input  NUM_BITS each  operands.
REQ-010 alu_a / alu_b  output  NUM_BITS each  operands driven to external combinational ALU.
REQ-011 alu_func  output  4  function code driven to ALU.
REQ-012 alu_c  input  NUM_BITS  ALU result, same cycle.
REQ-013 alu_flag  input  1  ALU flag, same cycle.
REQ-014 resp_valid  output  1  result present.
REQ-015 resp_ready  input  1  consumer accepts result.
REQ-016 resp_data  output  NUM_BITS  result.
REQ-017 resp_flag  output  1  result flag.

Function
REQ-018 States SHALL be IDLE, SINGLE, MUL_ADD, MUL_SHIFT, DONE.
REQ-019 req_ready SHALL be 1 only in IDLE with reset_n high; accept = req_valid & req_ready at a rising edge.
REQ-020 On accept, SHALL latch req_a, req_b, req_func, req_op; go SINGLE for op 00, MUL_ADD for op 01, SINGLE with func 1111 for ops 10/11.
REQ-021 In IDLE and DONE, SHALL drive alu_func=1111, alu_a=0, alu_b=0.
REQ-022 SINGLE: drive latched A, B, func; capture alu_c->resp_data and alu_flag->resp_flag at the edge; go DONE.
REQ-023 Multiply: acc=0, mcand=A, mplier=B at accept; iteration counter 0..MUL_ITERS-1.
REQ-024 MUL_ADD: alu_a=acc, alu_b=mcand, alu_func=0000 if mplier[0]=1 else 0010; acc<=alu_c; go MUL_SHIFT.
REQ-025 MUL_SHIFT: alu_a=mcand, alu_func=1100, alu_b=0; mcand<=alu_c; mplier shifted right by 1 internally; counter increments.
REQ-026 After MUL_SHIFT with counter==MUL_ITERS-1, SHALL go DONE with resp_data=acc (low NUM_BITS, overflow truncated), resp_flag=0; else back to MUL_ADD.
REQ-027 Latency: resp_valid SHALL rise 2 cycles after accept for single/reserved ops, 2*MUL_ITERS+1 (33) cycles for multiply.
REQ-028 DONE: resp_valid=1; resp_data/resp_flag SHALL hold stable until resp_valid & resp_ready, then IDLE next edge.
REQ-029 req_valid SHALL be ignored outside IDLE; no request queueing.
REQ-030 Next accept SHALL be possible one cycle after the response handshake (IDLE cycle).

Reset
REQ-031 reset_n low SHALL force, asynchronously: state IDLE, req_ready 0, resp_valid 0, resp_data 0, resp_flag 0, alu_a 0, alu_b 0, alu_func 1111, counter/acc/mcand/mplier 0.
REQ-032 Reset mid-operation SHALL abort it with no response issued; first edge after release SHALL see req_ready=1.

Structure
REQ-033 Shared package alu_pkg SHALL hold NUM_BITS, ALU function-code constants (ADD 0000, PASS_A 0010, SHL 1100, ZERO 1111), req_op encodings, state typedef.
REQ-034 No sub-module; ALU SHALL remain external, connected via alu_* ports at the parent.

Verification
REQ-035 Single add A=0x7FFF B=0x0001 func 0000 -> resp_data 0x8000, resp_flag 0, resp_valid 2 cycles after accept.
REQ-036 Single equal func 0111 A=B=0x1234 -> resp_data 0x1234, resp_flag 1; B=0x1235 -> flag 0.
REQ-037 Multiply 0x0003x0x0005 -> 0x000F after 33 cycles; 0x0100x0x0100 -> 0x0000; 0xFFFFx0xFFFF -> 0x0001.
REQ-038 resp_ready low 5 cycles -> resp_valid/resp_data stable, req_ready 0, asserted req_valid not accepted.
REQ-039 reset_n pulsed during multiply iteration 7 -> all outputs at reset values, no response; following single op 0x0002+0x0003 returns 0x0005.
REQ-040 req_valid held with resp_ready=1 -> back-to-back accepts exactly one IDLE cycle after each response handshake.
